// File: rtl/arm_pkg.sv
// Shared types and decode constants for the ARM-class fetch/execute sequencer.
package arm_pkg;

    localparam int unsigned INST_W = 16;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_LOAD  = 2'd1,
        ST_EXEC1 = 2'd2
    } state_t;

    localparam logic [1:0]        OPC_ARM  = 2'b11;
    localparam logic [1:0]        OPC_JMP  = 2'b10;
    localparam logic [INST_W-1:0] INST_HLT = 16'h0000;

    function automatic logic is_jmp(input logic [INST_W-1:0] inst);
        return inst[INST_W-1 -: 2] == OPC_JMP;
    endfunction

endpackage

// File: rtl/arm_sequencer_if.sv
// Sequencer-facing bundle: program memory port, ALU handshake and trace outputs.
interface arm_sequencer_if #(
    parameter int unsigned PC_WIDTH = 12
) ();
    logic                run;
    logic                pmem_en;
    logic [PC_WIDTH-1:0] pmem_addr;
    logic [15:0]         pmem_rdata;
    logic [15:0]         inst;
    logic                exec1;
    logic                skip_status;
    logic                cy_status;
    logic                skip_in;
    logic                skip_en_in;
    logic                cy_in;
    logic                cy_en_in;
    logic [PC_WIDTH-1:0] pc;
    logic                halted;

    modport master (
        input  run, pmem_rdata, skip_in, skip_en_in, cy_in, cy_en_in,
        output pmem_en, pmem_addr, inst, exec1, skip_status, cy_status, pc, halted
    );

    modport slave (
        output run, pmem_rdata, skip_in, skip_en_in, cy_in, cy_en_in,
        input  pmem_en, pmem_addr, inst, exec1, skip_status, cy_status, pc, halted
    );
endinterface

// File: rtl/arm_status_regs.sv
// Skip and carry status flops; skip self-clears when it squashes an instruction.
module arm_status_regs (
    input  logic clk,
    input  logic reset,
    input  logic i_exec,
    input  logic i_squash,
    input  logic i_skip,
    input  logic i_skip_en,
    input  logic i_cy,
    input  logic i_cy_en,
    output logic o_skip,
    output logic o_cy
);
    logic r_skip;
    logic r_cy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skip <= 1'b0;
            r_cy   <= 1'b0;
        end else begin
            if (i_squash)
                r_skip <= 1'b0;
            else if (i_exec && i_skip_en)
                r_skip <= i_skip;
            if (i_exec && i_cy_en)
                r_cy <= i_cy;
        end
    end

    assign o_skip = r_skip;
    assign o_cy   = r_cy;
endmodule

// File: rtl/arm_sequencer.sv
// Three-cycle fetch/load/execute sequencer owning PC, IR and halt for the ALU stage.
module arm_sequencer #(
    parameter int unsigned PC_WIDTH = 12,
    parameter int unsigned RESET_PC = 0
) (
    input  logic           clk,
    input  logic           reset,
    arm_sequencer_if.master bus
);
    import arm_pkg::*;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic [INST_W-1:0]   r_ir;
    logic [INST_W-1:0]   w_ir_nxt;
    logic                r_halted;
    logic                w_halted_nxt;
    logic                w_pmem_en;
    logic                w_skip;
    logic                w_cy;
    logic                w_in_exec;
    logic                w_exec1;
    logic                w_squash;

    assign w_in_exec = (r_state == ST_EXEC1);
    assign w_exec1   = w_in_exec & ~w_skip;
    assign w_squash  = w_in_exec & w_skip;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_FETCH;
            r_pc     <= PC_WIDTH'(RESET_PC);
            r_ir     <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_ir     <= w_ir_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Jump target written in EXEC1 overrides the increment applied in LOAD.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ir_nxt     = r_ir;
        w_halted_nxt = r_halted;
        w_pmem_en    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (bus.run && !r_halted) begin
                    w_pmem_en   = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_ir_nxt    = bus.pmem_rdata;
                w_pc_nxt    = r_pc + PC_WIDTH'(1);
                w_state_nxt = ST_EXEC1;
            end
            ST_EXEC1: begin
                w_state_nxt = ST_FETCH;
                if (w_exec1) begin
                    if (r_ir == INST_HLT)
                        w_halted_nxt = 1'b1;
                    else if (is_jmp(r_ir))
                        w_pc_nxt = r_ir[PC_WIDTH-1:0];
                end
            end
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    arm_status_regs u_status (
        .clk       (clk),
        .reset     (reset),
        .i_exec    (w_exec1),
        .i_squash  (w_squash),
        .i_skip    (bus.skip_in),
        .i_skip_en (bus.skip_en_in),
        .i_cy      (bus.cy_in),
        .i_cy_en   (bus.cy_en_in),
        .o_skip    (w_skip),
        .o_cy      (w_cy)
    );

    // Read enable is masked by reset so nothing is fetched while reset is held.
    assign bus.pmem_en     = w_pmem_en & ~reset;
    assign bus.pmem_addr   = r_pc;
    assign bus.inst        = r_ir;
    assign bus.exec1       = w_exec1;
    assign bus.skip_status = w_skip;
    assign bus.cy_status   = w_cy;
    assign bus.pc          = r_pc;
    assign bus.halted      = r_halted;
endmodule

// File: tb/tb_arm_sequencer.sv
// Directed bench for arm_sequencer with a synchronous program memory model.
module tb_arm_sequencer;
    localparam int unsigned PC_WIDTH = 12;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [15:0] mem [0:4095];

    arm_sequencer_if #(.PC_WIDTH(PC_WIDTH)) bus ();

    arm_sequencer #(.PC_WIDTH(PC_WIDTH), .RESET_PC(0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.pmem_en) bus.pmem_rdata <= mem[bus.pmem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nx(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 4096; i++) mem[i] = v;
    endtask

    // Holds reset for a cycle with run high, checks reset values, releases at a negedge.
    task automatic do_reset();
        reset          = 1'b1;
        bus.run        = 1'b1;
        bus.skip_in    = 1'b0;
        bus.skip_en_in = 1'b0;
        bus.cy_in      = 1'b0;
        bus.cy_en_in   = 1'b0;
        nx();
        check("rst_pc",      32'(bus.pc), 0);
        check("rst_pmem_en", 32'(bus.pmem_en), 0);
        check("rst_exec1",   32'(bus.exec1), 0);
        check("rst_inst",    32'(bus.inst), 0);
        check("rst_skip",    32'(bus.skip_status), 0);
        check("rst_cy",      32'(bus.cy_status), 0);
        check("rst_halted",  32'(bus.halted), 0);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        bus.pmem_rdata = '0;

        // Three ALU ops in a row: fetch addresses and exec1 cadence
        fill(16'hC000);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            check("t1_addr", 32'(bus.pmem_addr), 32'(i));
            check("t1_en",   32'(bus.pmem_en), 1);
            nx();
            check("t1_load_exec1", 32'(bus.exec1), 0);
            nx();
            check("t1_exec1", 32'(bus.exec1), 1);
            check("t1_pc",    32'(bus.pc), 32'(i + 1));
            nx();
        end

        // Skip set by the ALU squashes the next instruction only
        fill(16'hC000);
        do_reset();
        nx(2);
        check("t2_exec0", 32'(bus.exec1), 1);
        bus.skip_en_in = 1'b1; bus.skip_in = 1'b1;
        nx();
        bus.skip_en_in = 1'b0; bus.skip_in = 1'b0;
        check("t2_skip_set", 32'(bus.skip_status), 1);
        nx(2);
        check("t2_squash", 32'(bus.exec1), 0);
        nx();
        check("t2_skip_clr", 32'(bus.skip_status), 0);
        nx(2);
        check("t2_exec2", 32'(bus.exec1), 1);

        // Taken jump
        fill(16'hC000);
        mem[0] = 16'h8005;
        do_reset();
        nx(2);
        check("t3_jmp_exec", 32'(bus.exec1), 1);
        nx();
        check("t3_jmp_addr", 32'(bus.pmem_addr), 5);
        check("t3_jmp_pc",   32'(bus.pc), 5);

        // Squashed jump falls through to pc+1
        fill(16'hC000);
        mem[1] = 16'h8005;
        do_reset();
        nx(2);
        bus.skip_en_in = 1'b1; bus.skip_in = 1'b1;
        nx();
        bus.skip_en_in = 1'b0; bus.skip_in = 1'b0;
        nx(2);
        check("t3s_exec", 32'(bus.exec1), 0);
        check("t3s_inst", 32'(bus.inst), 32'h8005);
        nx();
        check("t3s_addr", 32'(bus.pmem_addr), 2);

        // Carry only updates in an executed EXEC1
        fill(16'hC000);
        do_reset();
        bus.cy_en_in = 1'b1; bus.cy_in = 1'b1;
        nx();
        check("t4_cy_load", 32'(bus.cy_status), 0);
        nx();
        check("t4_cy_exec", 32'(bus.cy_status), 0);
        bus.skip_en_in = 1'b1; bus.skip_in = 1'b1;
        nx();
        check("t4_cy_set", 32'(bus.cy_status), 1);
        bus.skip_en_in = 1'b0; bus.skip_in = 1'b0; bus.cy_in = 1'b0;
        nx();
        check("t4_cy_hold_load", 32'(bus.cy_status), 1);
        nx();
        check("t4_squash", 32'(bus.exec1), 0);
        nx();
        check("t4_cy_hold_sq", 32'(bus.cy_status), 1);
        check("t4_skip_clr",   32'(bus.skip_status), 0);
        bus.cy_en_in = 1'b0;

        // Halt is sticky and ignores run
        fill(16'hC000);
        mem[1] = 16'h0000;
        do_reset();
        nx(5);
        check("t5_hlt_exec", 32'(bus.exec1), 1);
        check("t5_hlt_inst", 32'(bus.inst), 0);
        nx();
        check("t5_halted", 32'(bus.halted), 1);
        check("t5_en",     32'(bus.pmem_en), 0);
        for (int i = 0; i < 6; i++) begin
            bus.run = ~bus.run;
            nx();
            check("t5_en_run",  32'(bus.pmem_en), 0);
            check("t5_exec_run", 32'(bus.exec1), 0);
        end
        check("t5_pc", 32'(bus.pc), 2);
        bus.run = 1'b1;

        // Async reset during LOAD at pc=7
        fill(16'h4000);
        mem[0] = 16'h8007;
        do_reset();
        nx(2);
        bus.cy_en_in = 1'b1; bus.cy_in = 1'b1;
        nx();
        bus.cy_en_in = 1'b0; bus.cy_in = 1'b0;
        check("t6_cy_pre",   32'(bus.cy_status), 1);
        check("t6_addr_pre", 32'(bus.pmem_addr), 7);
        nx();
        check("t6_pc_load", 32'(bus.pc), 7);
        reset = 1'b1;
        #1;
        check("t6_pc",    32'(bus.pc), 0);
        check("t6_exec1", 32'(bus.exec1), 0);
        check("t6_skip",  32'(bus.skip_status), 0);
        check("t6_cy",    32'(bus.cy_status), 0);
        check("t6_en",    32'(bus.pmem_en), 0);
        check("t6_inst",  32'(bus.inst), 0);
        nx();
        reset = 1'b0;
        #1;
        check("t6_restart_addr", 32'(bus.pmem_addr), 0);
        check("t6_restart_en",   32'(bus.pmem_en), 1);
        nx(2);
        check("t6_restart_exec", 32'(bus.exec1), 1);
        check("t6_restart_inst", 32'(bus.inst), 32'h8007);

        // run dropped during EXEC1 parks in FETCH
        fill(16'hC000);
        do_reset();
        nx(2);
        bus.run = 1'b0;
        nx();
        check("t7_en_off", 32'(bus.pmem_en), 0);
        nx();
        check("t7_en_hold",   32'(bus.pmem_en), 0);
        check("t7_exec_hold", 32'(bus.exec1), 0);
        check("t7_pc_hold",   32'(bus.pc), 1);
        bus.run = 1'b1;
        #1;
        check("t7_resume_en",   32'(bus.pmem_en), 1);
        check("t7_resume_addr", 32'(bus.pmem_addr), 1);

        // PC wrap from all-ones
        fill(16'hC000);
        mem[0] = 16'h8FFF;
        do_reset();
        nx(3);
        check("t8_addr_top", 32'(bus.pmem_addr), 32'hFFF);
        nx(2);
        check("t8_exec", 32'(bus.exec1), 1);
        check("t8_pc_wrap", 32'(bus.pc), 0);
        nx();
        check("t8_addr_wrap", 32'(bus.pmem_addr), 0);

        // Jump to own address loops
        fill(16'hC000);
        mem[0] = 16'h8000;
        do_reset();
        nx(3);
        check("t9_addr1", 32'(bus.pmem_addr), 0);
        nx(2);
        check("t9_exec", 32'(bus.exec1), 1);
        nx();
        check("t9_addr2", 32'(bus.pmem_addr), 0);
        check("t9_halted", 32'(bus.halted), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
